// File: rtl/ars_gf233_pkg.sv
// Shared GF(2^233) definitions: field size, reduction tap, element type, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ars_gf233_pkg;

  localparam int M             = 233;
  localparam int REDUCTION_TAP = 74;

  typedef logic [M-1:0] gf233_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } msquar_state_t;

endpackage

// File: rtl/ars_msquar_if.sv
// Operand/result handshake bundle between the operand registers and the multi-squarer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand side and the result side.
interface ars_msquar_if
  import ars_gf233_pkg::*;
#(
  parameter int KW = 8
);

  logic          IN_VALID;
  logic          IN_READY;
  gf233_t        DIN;
  logic [KW-1:0] K;
  logic          OUT_VALID;
  logic          OUT_READY;
  gf233_t        DOUT;

  // Upstream side: presents operands and consumes results.
  modport master (
    output IN_VALID, DIN, K, OUT_READY,
    input  IN_READY, OUT_VALID, DOUT
  );

  // Multi-squarer side.
  modport slave (
    input  IN_VALID, DIN, K, OUT_READY,
    output IN_READY, OUT_VALID, DOUT
  );

endinterface

// File: rtl/ars_msquar_squar.sv
// Combinational GF(2^233) squarer modulo x^233 + x^74 + 1.
// Latency: 0 cycles (at most 2 XOR levels per output bit).
// Backpressure: none, purely combinational.
module ARS_squar
  import ars_gf233_pkg::*;
(
  input  gf233_t a,
  output gf233_t sq
);

  // Coefficient a[i] lands on x^(2i). Below H0 it needs no reduction, below H1
  // one fold through x^233 = x^74 + 1 suffices, above that the folded upper
  // term overflows again and is folded a second time.
  localparam int H0 = (M + 1) / 2;
  localparam int H1 = (2 * M - REDUCTION_TAP + 1) / 2;

  // Spread the coefficients and fold the overflowing ones back into range.
  always_comb begin
    sq = '0;
    for (int i = 0; i < H0; i++) begin
      sq[2*i] = sq[2*i] ^ a[i];
    end
    for (int i = H0; i < H1; i++) begin
      sq[2*i-M]               = sq[2*i-M] ^ a[i];
      sq[2*i-M+REDUCTION_TAP] = sq[2*i-M+REDUCTION_TAP] ^ a[i];
    end
    for (int i = H1; i < M; i++) begin
      sq[2*i-M]                     = sq[2*i-M] ^ a[i];
      sq[2*i-2*M+REDUCTION_TAP]     = sq[2*i-2*M+REDUCTION_TAP] ^ a[i];
      sq[2*i-2*M+2*REDUCTION_TAP]   = sq[2*i-2*M+2*REDUCTION_TAP] ^ a[i];
    end
  end

endmodule

// File: rtl/ars_msquar.sv
// Sequential multi-squarer: DOUT = DIN^(2^K) in GF(2^233), SQ_PER_CYC squarings per cycle.
// Latency: ceil(K/SQ_PER_CYC)+1 cycles from the accept cycle to OUT_VALID.
// Backpressure: result held in DONE until OUT_READY; no new operand accepted until back in IDLE.
module ars_msquar
  import ars_gf233_pkg::*;
#(
  parameter int SQ_PER_CYC = 1,
  parameter int KW         = 8
)(
  input  logic         CLK,
  input  logic         RST_N,
  ars_msquar_if.slave  io
);

  localparam logic [KW-1:0] SQ_W = KW'(SQ_PER_CYC);

  msquar_state_t state_q, state_d;
  gf233_t        acc_q, acc_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] step;
  gf233_t        acc_nxt;

  // tap[j] is acc squared j times.
  gf233_t tap [SQ_PER_CYC+1];

  assign tap[0] = acc_q;

  for (genvar j = 0; j < SQ_PER_CYC; j++) begin : g_sq
    ARS_squar u_sq (
      .a  (tap[j]),
      .sq (tap[j+1])
    );
  end

  // Squarings applied this cycle: a full chain, or whatever is left of the count.
  always_comb begin
    step = (cnt_q < SQ_W) ? cnt_q : SQ_W;
  end

  // Tap mux selecting acc squared 'step' times.
  always_comb begin
    acc_nxt = tap[0];
    for (int j = 1; j <= SQ_PER_CYC; j++) begin
      if (step == KW'(j)) acc_nxt = tap[j];
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (io.IN_VALID) begin
          acc_d   = io.DIN;
          cnt_d   = io.K;
          state_d = (io.K == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q - step;
        if (cnt_q == step) state_d = DONE;
      end
      DONE: begin
        if (io.OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulator and remaining-count registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs depend on state only; DOUT is gated so intermediate
  // accumulator values never leave the block.
  assign io.IN_READY  = (state_q == IDLE);
  assign io.OUT_VALID = (state_q == DONE);
  assign io.DOUT      = (state_q == DONE) ? acc_q : '0;

endmodule

// File: tb/tb_ars_msquar.sv
// Bench for ars_msquar: one SQ_PER_CYC=1 and one SQ_PER_CYC=4 instance against a field model.
// Latency: checked per operand against ceil(K/S)+1.
// Backpressure: random OUT_READY stalls plus a held-low window.
module tb_ars_msquar;
  import ars_gf233_pkg::*;

  localparam int KW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     [2] = '{1'b0, 1'b0};
  logic          in_valid  [2] = '{1'b0, 1'b0};
  logic          out_ready [2] = '{1'b0, 1'b0};
  gf233_t        din       [2];
  logic [KW-1:0] kin       [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  gf233_t        dout      [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state per instance.
  bit     pending   [2] = '{1'b0, 1'b0};
  gf233_t exp_q     [2];
  int     ready_cyc [2];

  ars_msquar_if #(.KW(KW)) if1 ();
  ars_msquar_if #(.KW(KW)) if4 ();

  assign if1.IN_VALID  = in_valid[0];
  assign if1.DIN       = din[0];
  assign if1.K         = kin[0];
  assign if1.OUT_READY = out_ready[0];
  assign in_ready[0]   = if1.IN_READY;
  assign out_valid[0]  = if1.OUT_VALID;
  assign dout[0]       = if1.DOUT;

  assign if4.IN_VALID  = in_valid[1];
  assign if4.DIN       = din[1];
  assign if4.K         = kin[1];
  assign if4.OUT_READY = out_ready[1];
  assign in_ready[1]   = if4.IN_READY;
  assign out_valid[1]  = if4.OUT_VALID;
  assign dout[1]       = if4.DOUT;

  ars_msquar #(.SQ_PER_CYC(1), .KW(KW)) u_dut1 (
    .CLK   (clk),
    .RST_N (rst_n[0]),
    .io    (if1)
  );

  ars_msquar #(.SQ_PER_CYC(4), .KW(KW)) u_dut4 (
    .CLK   (clk),
    .RST_N (rst_n[1]),
    .io    (if4)
  );

  // ---------------- field model ----------------
  // Generic shift-and-add multiplication modulo x^233 + x^74 + 1.
  function automatic gf233_t gf_mul(gf233_t a, gf233_t b);
    logic [M:0] r;
    logic [M:0] f;
    f = '0;
    f[M] = 1'b1;
    f[REDUCTION_TAP] = 1'b1;
    f[0] = 1'b1;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = {r[M-1:0], 1'b0};
      if (r[M]) r = r ^ f;
      if (b[i]) r[M-1:0] = r[M-1:0] ^ a;
    end
    return r[M-1:0];
  endfunction

  function automatic gf233_t pow2k(gf233_t a, int k);
    gf233_t x;
    x = a;
    repeat (k) x = gf_mul(x, x);
    return x;
  endfunction

  function automatic int sqv(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int lat_of(int k, int s);
    return (k + s - 1) / s + 1;
  endfunction

  function automatic gf233_t rand_gf();
    gf233_t r;
    for (int i = 0; i < M; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic check_gf(input string name, input gf233_t act, input gf233_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model update at each clock edge ----------------
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] !== 1'b1) begin
        pending[d] = 1'b0;
      end else if (pending[d]) begin
        if (cyc >= ready_cyc[d] && out_ready[d] === 1'b1) pending[d] = 1'b0;
      end else if (in_valid[d] === 1'b1) begin
        pending[d]   = 1'b1;
        exp_q[d]     = pow2k(din[d], int'(kin[d]));
        ready_cyc[d] = cyc + lat_of(int'(kin[d]), sqv(d));
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp_p
    bit ev;
    bit idle;
    for (int d = 0; d < 2; d++) begin
      ev   = (rst_n[d] === 1'b1) && pending[d] && (cyc >= ready_cyc[d]);
      idle = (rst_n[d] !== 1'b1) || !pending[d];
      check_int($sformatf("out_valid[%0d] cyc %0d", d, cyc), int'(out_valid[d]), int'(ev));
      check_int($sformatf("in_ready[%0d] cyc %0d", d, cyc), int'(in_ready[d]), int'(idle));
      if (ev) check_gf($sformatf("dout[%0d] cyc %0d", d, cyc), dout[d], exp_q[d]);
    end
  end

  // ---------------- drivers ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int d, input gf233_t a, input int kk, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    din[d] = a;
    kin[d] = KW'(kk);
    in_valid[d] = 1'b1;
    while (in_ready[d] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (in_ready[d] !== 1'b1) begin
      check_int($sformatf("send_timeout[%0d]", d), 0, 1);
      in_valid[d] = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  // Waits for the result, stalls 'hold' cycles, then consumes it.
  task automatic get(input int d, input int hold, output gf233_t q, output int ov_cyc);
    int n;
    n = 0;
    q = '0;
    ov_cyc = -1;
    while (out_valid[d] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (out_valid[d] !== 1'b1) begin
      check_int($sformatf("result_timeout[%0d]", d), 0, 1);
      return;
    end
    ov_cyc = cyc;
    repeat (hold) @(negedge clk);
    q = dout[d];
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic reset_checks(input int d);
    check_int($sformatf("rst_out_valid[%0d]", d), int'(out_valid[d]), 0);
    check_int($sformatf("rst_in_ready[%0d]", d), int'(in_ready[d]), 1);
    check_gf($sformatf("rst_dout[%0d]", d), dout[d], '0);
  endtask

  // One operand with result and latency checked against the model.
  task automatic op(input int d, input gf233_t a, input int kk, input int hold, input string name);
    gf233_t q;
    int ac, ov;
    send(d, a, kk, ac);
    get(d, hold, q, ov);
    check_gf({name, "_dout"}, q, pow2k(a, kk));
    check_int({name, "_lat"}, ov - ac, lat_of(kk, sqv(d)));
  endtask

  // Stimulus for the single-squarer instance.
  task automatic drive0();
    gf233_t e, t, r, q0, q;
    int ac, ov, kk;
    repeat (3) @(negedge clk);
    reset_checks(0);
    rst_n[0] = 1'b1;
    @(negedge clk);

    // Pin the model with hand-computed values.
    e = '0; e[1] = 1'b1;
    t = '0; t[2] = 1'b1;
    check_gf("model_x1", pow2k(e, 1), t);
    e = '0; e[117] = 1'b1;
    t = '0; t[75] = 1'b1; t[1] = 1'b1;
    check_gf("model_x117", pow2k(e, 1), t);
    e = '0; e[116] = 1'b1;
    t = '0; t[232] = 1'b1;
    check_gf("model_x116", pow2k(e, 1), t);
    r = rand_gf();
    check_gf("model_frobenius", pow2k(r, 233), r);

    // Directed single-bit operands against literal expectations.
    e = '0; e[1] = 1'b1;
    t = '0; t[2] = 1'b1;
    send(0, e, 1, ac);
    get(0, 0, q, ov);
    check_gf("x1_dout", q, t);
    check_int("x1_lat", ov - ac, 2);

    e = '0; e[117] = 1'b1;
    t = '0; t[75] = 1'b1; t[1] = 1'b1;
    send(0, e, 1, ac);
    get(0, 0, q, ov);
    check_gf("x117_dout", q, t);

    e = '0; e[116] = 1'b1;
    t = '0; t[232] = 1'b1;
    send(0, e, 1, ac);
    get(0, 0, q, ov);
    check_gf("x116_dout", q, t);

    // Frobenius period and the K=0 path.
    send(0, r, 233, ac);
    get(0, 0, q, ov);
    check_gf("k233_dout", q, r);
    check_int("k233_lat", ov - ac, 234);
    send(0, r, 0, ac);
    get(0, 0, q, ov);
    check_gf("k0_dout", q, r);
    check_int("k0_lat", ov - ac, 1);
    op(0, rand_gf(), 255, 0, "k255");

    // Result held under backpressure.
    send(0, rand_gf(), 30, ac);
    get(0, 0, q, ov);
    r = rand_gf();
    send(0, r, 12, ac);
    while (out_valid[0] !== 1'b1 && cyc < ac + 100) @(negedge clk);
    q0 = pow2k(r, 12);
    for (int i = 0; i < 10; i++) begin
      check_gf("bp_dout_stable", dout[0], q0);
      check_int("bp_out_valid", int'(out_valid[0]), 1);
      check_int("bp_in_ready", int'(in_ready[0]), 0);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check_int("bp_release_in_ready", int'(in_ready[0]), 1);
    check_int("bp_release_out_valid", int'(out_valid[0]), 0);

    // Asynchronous reset in the middle of a long run.
    send(0, rand_gf(), 200, ac);
    repeat (50) @(negedge clk);
    #2;
    rst_n[0] = 1'b0;
    #1;
    reset_checks(0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    op(0, rand_gf(), 17, 1, "post_reset");

    // Random operands, random stalls, stray IN_VALID while busy.
    for (int n = 0; n < 1000; n++) begin
      kk = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
      r = rand_gf();
      send(0, r, kk, ac);
      if (kk >= 4 && $urandom_range(0, 3) == 0) begin
        din[0] = rand_gf();
        kin[0] = KW'($urandom_range(0, 255));
        in_valid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
      end
      get(0, int'($urandom_range(0, 3)), q, ov);
      check_int("rand1_lat", ov - ac, lat_of(kk, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Stimulus for the four-squarer instance.
  task automatic drive1();
    gf233_t r, q;
    int ac, ov, kk;
    repeat (3) @(negedge clk);
    reset_checks(1);
    rst_n[1] = 1'b1;
    @(negedge clk);

    r = rand_gf();
    send(1, r, 5, ac);
    get(1, 0, q, ov);
    check_gf("sq4_k5_dout", q, pow2k(r, 5));
    check_int("sq4_k5_lat", ov - ac, 3);

    op(1, rand_gf(), 0, 0, "sq4_k0");
    op(1, rand_gf(), 3, 0, "sq4_k3");
    op(1, rand_gf(), 4, 0, "sq4_k4");
    op(1, rand_gf(), 8, 0, "sq4_k8");
    op(1, rand_gf(), 255, 0, "sq4_k255");

    for (int n = 0; n < 300; n++) begin
      kk = int'($urandom_range(0, 255));
      send(1, rand_gf(), kk, ac);
      get(1, int'($urandom_range(0, 2)), q, ov);
      check_int("rand4_lat", ov - ac, lat_of(kk, 4));
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
  endtask

  initial begin
    din[0] = '0; din[1] = '0;
    kin[0] = '0; kin[1] = '0;
    fork
      drive0();
      drive1();
    join
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
